diff_window_acc: RTL and testbench

- Downstream consumer of the signed 9-bit difference stream produced by the difference stage.
- Collects a window of N differences over a valid/ready handshake.
- Reports sum, arithmetic mean, min, max and positive-sample count for that window, then holds the result until a downstream sink accepts it.
- Used for statistics and monitoring on difference results in the assignment datapaths.

---
 rtl/diff_window_acc.sv | 146 ++++++++++++++
 tb/tb_diff_window_acc.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/diff_window_acc.sv
// Windowed statistics over a signed difference stream: sum, mean, min, max and positive count per N samples.
// Optional saturating accumulator enabled by defining DIFF_SAT_EN; otherwise the sum wraps and out_sat is 0.
module diff_window_acc #(
  parameter int DW    = 9,
  parameter int N     = 8,
  parameter int ACC_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW-1:0]            in_diff,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_sum,
  output logic [ACC_W-1:0]         out_mean,
  output logic [DW-1:0]            out_min,
  output logic [DW-1:0]            out_max,
  output logic [$clog2(N+1)-1:0]   out_pos_cnt,
  output logic                     out_sat,
  output logic                     dbg_state
);

  localparam int CNT_W = $clog2(N);
  localparam int PW    = $clog2(N+1);
  localparam int SH    = $clog2(N);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  // Handshake: a sample moves on a rising edge with in_valid && in_ready; a result moves with out_valid && out_ready.
  state_t                   r_state, w_state_next;
  logic [CNT_W-1:0]         r_cnt;
  logic signed [ACC_W-1:0]  r_acc, w_acc_next;
  logic [PW-1:0]            r_pos, w_pos_next;
  logic [DW-1:0]            r_min, r_max, w_min_next, w_max_next;
  logic signed [ACC_W-1:0]  r_out_sum;
  logic [DW-1:0]            r_out_min, r_out_max;
  logic [PW-1:0]            r_out_pos;
  logic                     w_accept, w_last, w_done, w_first, w_is_pos;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ACCUM;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      ACCUM: begin
        in_ready = rst_n;
        if (in_valid && w_last) w_state_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = ACCUM;
      end
      default: w_state_next = ACCUM;
    endcase
  end

  assign w_accept = in_valid && in_ready;
  assign w_done   = out_valid && out_ready;
  assign w_last   = (r_cnt == CNT_W'(N-1));
  assign w_first  = (r_cnt == '0);
  assign w_is_pos = !in_diff[DW-1] && (in_diff != '0);

  // The first sample of a window seeds both extremes regardless of stale contents.
  assign w_min_next = (w_first || ($signed(in_diff) < $signed(r_min))) ? in_diff : r_min;
  assign w_max_next = (w_first || ($signed(in_diff) > $signed(r_max))) ? in_diff : r_max;
  assign w_pos_next = r_pos + PW'(w_is_pos);

`ifdef DIFF_SAT_EN
  logic signed [ACC_W:0] w_sum_wide;
  logic                  w_clip;
  logic                  r_sat, r_out_sat;

  // One extra bit makes the add exact; a disagreement of the top two bits means the result left range.
  assign w_sum_wide = $signed({r_acc[ACC_W-1], r_acc}) + (ACC_W+1)'($signed(in_diff));
  assign w_clip     = w_sum_wide[ACC_W] ^ w_sum_wide[ACC_W-1];

  always_comb begin
    w_acc_next = w_sum_wide[ACC_W-1:0];
    if (w_clip) begin
      if (w_sum_wide[ACC_W]) w_acc_next = {1'b1, {(ACC_W-1){1'b0}}};
      else                   w_acc_next = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat     <= 1'b0;
      r_out_sat <= 1'b0;
    end else if (w_accept) begin
      r_sat <= r_sat | w_clip;
      if (w_last) r_out_sat <= r_sat | w_clip;
    end else if (w_done) begin
      r_sat <= 1'b0;
    end
  end

  assign out_sat = r_out_sat;
`else
  assign w_acc_next = r_acc + ACC_W'($signed(in_diff));
  assign out_sat    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_pos     <= '0;
      r_min     <= '0;
      r_max     <= '0;
      r_out_sum <= '0;
      r_out_min <= '0;
      r_out_max <= '0;
      r_out_pos <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= w_acc_next;
      r_pos <= w_pos_next;
      r_min <= w_min_next;
      r_max <= w_max_next;
      if (w_last) begin
        r_out_sum <= w_acc_next;
        r_out_min <= w_min_next;
        r_out_max <= w_max_next;
        r_out_pos <= w_pos_next;
      end
    end else if (w_done) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_pos <= '0;
    end
  end

  assign out_sum     = r_out_sum;
  assign out_mean    = r_out_sum >>> SH;
  assign out_min     = r_out_min;
  assign out_max     = r_out_max;
  assign out_pos_cnt = r_out_pos;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_diff_window_acc.sv
// Bench for diff_window_acc: two instances (16-bit and 10-bit accumulators, N=4) share one stimulus stream.
// Expected windows come from an arithmetic model queued on acceptance and popped on each output handshake.
module tb_diff_window_acc;

  localparam int NW = 4;
`ifdef DIFF_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [8:0]  in_diff = '0;

  logic        in_ready_a, out_valid_a, out_sat_a, dbg_a;
  logic [15:0] out_sum_a, out_mean_a;
  logic [8:0]  out_min_a, out_max_a;
  logic [2:0]  out_pos_a;

  logic        in_ready_b, out_valid_b, out_sat_b, dbg_b;
  logic [9:0]  out_sum_b, out_mean_b;
  logic [8:0]  out_min_b, out_max_b;
  logic [2:0]  out_pos_b;

  always #5 clk = ~clk;

  diff_window_acc #(.DW(9), .N(NW), .ACC_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a), .in_diff(in_diff),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_sum(out_sum_a), .out_mean(out_mean_a),
    .out_min(out_min_a), .out_max(out_max_a), .out_pos_cnt(out_pos_a), .out_sat(out_sat_a),
    .dbg_state(dbg_a)
  );

  diff_window_acc #(.DW(9), .N(NW), .ACC_W(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b), .in_diff(in_diff),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_sum(out_sum_b), .out_mean(out_mean_b),
    .out_min(out_min_b), .out_max(out_max_b), .out_pos_cnt(out_pos_b), .out_sat(out_sat_b),
    .dbg_state(dbg_b)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  int          win[$];
  bit          m_hold = 1'b0;
  // packed: sum[53:38] mean[37:22] min[21:13] max[12:4] pos[3:1] sat[0]
  logic [53:0] exp16_q[$];
  logic [53:0] exp10_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic over the collected window for an accumulator of width w.
  function automatic logic [53:0] model(input int w);
    int s, mn, mx, pos, mean, lo, hi, m;
    bit sat;
    lo = -(1 << (w-1));
    hi = (1 << (w-1)) - 1;
    m  = 1 << w;
    s = 0; sat = 1'b0; pos = 0; mn = win[0]; mx = win[0];
    foreach (win[i]) begin
      s += win[i];
      if (SAT_EN) begin
        if (s > hi) begin s = hi; sat = 1'b1; end
        else if (s < lo) begin s = lo; sat = 1'b1; end
      end
      if (win[i] < mn) mn = win[i];
      if (win[i] > mx) mx = win[i];
      if (win[i] > 0) pos++;
    end
    if (!SAT_EN) s = ((s - lo) % m + m) % m + lo;
    mean = (s >= 0) ? s / NW : -((-s + NW - 1) / NW);
    return {16'(s), 16'(mean), 9'(mn), 9'(mx), 3'(pos), sat};
  endfunction

  task automatic cmp_out(input string tag, input logic [53:0] act, input logic [53:0] exp);
    check({tag, "_sum"},  int'($signed(act[53:38])), int'($signed(exp[53:38])));
    check({tag, "_mean"}, int'($signed(act[37:22])), int'($signed(exp[37:22])));
    check({tag, "_min"},  int'($signed(act[21:13])), int'($signed(exp[21:13])));
    check({tag, "_max"},  int'($signed(act[12:4])),  int'($signed(exp[12:4])));
    check({tag, "_pos"},  int'(act[3:1]),            int'(exp[3:1]));
    check({tag, "_sat"},  int'(act[0]),              int'(exp[0]));
  endtask

  // ---------------- input tracker: handshake model and expectation push ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready_a", int'(in_ready_a), int'(!m_hold));
      check("in_ready_b", int'(in_ready_b), int'(!m_hold));
      check("out_valid_a", int'(out_valid_a), int'(m_hold));
      check("out_valid_b", int'(out_valid_b), int'(m_hold));
      check("dbg_state", int'(dbg_a), int'(m_hold));
      if (!m_hold) begin
        if (in_valid) begin
          win.push_back(int'($signed(in_diff)));
          if (win.size() == NW) begin
            exp16_q.push_back(model(16));
            exp10_q.push_back(model(10));
            win.delete();
            m_hold = 1'b1;
          end
        end
      end else if (out_ready) begin
        m_hold = 1'b0;
      end
    end
  end

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid_a) begin
        if (exp16_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL w16_spurious: out_valid=1 with no expected window at %0t", $time);
        end else begin
          cmp_out("w16", {out_sum_a, out_mean_a, out_min_a, out_max_a, out_pos_a, out_sat_a}, exp16_q[0]);
          if (out_ready) void'(exp16_q.pop_front());
        end
      end
      if (out_valid_b) begin
        if (exp10_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL w10_spurious: out_valid=1 with no expected window at %0t", $time);
        end else begin
          cmp_out("w10", {16'($signed(out_sum_b)), 16'($signed(out_mean_b)), out_min_b, out_max_b,
                          out_pos_b, out_sat_b}, exp10_q[0]);
          if (out_ready) void'(exp10_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_sample(input int d);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_diff  = 9'(d);
    @(negedge clk);
    while (!in_ready_a && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (t >= 50) begin
      n_fail++;
      $display("FAIL push_timeout: in_ready stayed 0, expected 1 within 50 cycles at %0t", $time);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_window(input bit narrow, input int s, input int mn_v, input int lo_v,
                               input int hi_v, input int p, input int st);
    int t;
    t = 0;
    @(negedge clk);
    while (!(narrow ? out_valid_b : out_valid_a) && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (t >= 20) begin
      n_fail++;
      $display("FAIL dir_timeout: out_valid stayed 0, expected 1 within 20 cycles at %0t", $time);
    end else if (narrow) begin
      check("dir10_sum",  int'($signed(out_sum_b)),  s);
      check("dir10_mean", int'($signed(out_mean_b)), mn_v);
      check("dir10_min",  int'($signed(out_min_b)),  lo_v);
      check("dir10_max",  int'($signed(out_max_b)),  hi_v);
      check("dir10_pos",  int'(out_pos_b),           p);
      check("dir10_sat",  int'(out_sat_b),           st);
    end else begin
      check("dir16_sum",  int'($signed(out_sum_a)),  s);
      check("dir16_mean", int'($signed(out_mean_a)), mn_v);
      check("dir16_min",  int'($signed(out_min_a)),  lo_v);
      check("dir16_max",  int'($signed(out_max_a)),  hi_v);
      check("dir16_pos",  int'(out_pos_a),           p);
      check("dir16_sat",  int'(out_sat_a),           st);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid_a"}, int'(out_valid_a), 0);
    check({tag, "_valid_b"}, int'(out_valid_b), 0);
    check({tag, "_ready_a"}, int'(in_ready_a), 0);
    check({tag, "_sum_a"},   int'(out_sum_a), 0);
    check({tag, "_mean_a"},  int'(out_mean_a), 0);
    check({tag, "_min_a"},   int'(out_min_a), 0);
    check({tag, "_max_a"},   int'(out_max_a), 0);
    check({tag, "_pos_a"},   int'(out_pos_a), 0);
    check({tag, "_sat_a"},   int'(out_sat_a), 0);
    check({tag, "_sum_b"},   int'(out_sum_b), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pulses, first_i, last_i;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    out_ready = 1'b1;

    push_sample(10); push_sample(-10); push_sample(25); push_sample(-20);
    expect_window(1'b0, 5, 1, -20, 25, 2, 0);

    repeat (4) push_sample(-256);
    expect_window(1'b0, -1024, -256, -256, -256, 0, 0);

    push_sample(-5); push_sample(0); push_sample(0); push_sample(0);
    expect_window(1'b0, -5, -2, -5, 0, 0, 0);

    // backpressure with a stray valid sample offered during the stall
    out_ready = 1'b0;
    push_sample(1); push_sample(2); push_sample(3); push_sample(4);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_diff  = 9'd99;
      @(negedge clk);
      check("stall_valid", int'(out_valid_a), 1);
      check("stall_ready", int'(in_ready_a), 0);
      check("stall_sum",   int'($signed(out_sum_a)), 10);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    push_sample(5); push_sample(6); push_sample(7); push_sample(8);
    expect_window(1'b0, 26, 6, 5, 8, 4, 0);

    // asynchronous reset between clock edges in the middle of a window
    push_sample(7); push_sample(7);
    #1;
    rst_n = 1'b0;
    win.delete();
    m_hold = 1'b0;
    #1;
    check_all_zero("midrst");
    #1;
    rst_n = 1'b1;
    repeat (4) push_sample(1);
    expect_window(1'b0, 4, 1, 1, 1, 4, 0);

    repeat (4) push_sample(255);
    expect_window(1'b1, SAT_EN ? 511 : -4, SAT_EN ? 127 : -1, 255, 255, 4, SAT_EN ? 1 : 0);

    // minimum window period with both sides always ready
    pulses = 0; first_i = -1; last_i = -1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_diff  = 9'($urandom_range(0, 511));
      @(negedge clk);
      if (out_valid_a) begin
        pulses++;
        if (first_i < 0) first_i = i;
        last_i = i;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("minper_pulses",  pulses, 2);
    check("minper_spacing", last_i - first_i, NW + 1);

    // randomized traffic with corner values and random backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0:       in_diff = 9'h100;
        1:       in_diff = 9'h0FF;
        2:       in_diff = 9'h000;
        default: in_diff = 9'($urandom_range(0, 511));
      endcase
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("drain_q16", exp16_q.size(), 0);
    check("drain_q10", exp10_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
